imem_loader: RTL

Boot-time program loader sitting upstream of the single-cycle processor. Accepts a framed byte stream over a valid/ready handshake, assembles little-endian 32-bit instruction words, writes them into instruction memory through a word-indexed write port, verifies an XOR checksum, then releases the processor by raising `cpu_run`. The processor's reset is driven from `cpu_run` externally, so the CPU never fetches from a partially loaded memory.

---
 rtl/imem_loader_pkg.sv | 18 +
 rtl/imem_loader_word_assembler.sv | 35 +++
 rtl/imem_loader.sv | 134 +++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types for the boot-time instruction-memory loader.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package loader_pkg;

    typedef enum logic [2:0] {
        LEN0,
        LEN1,
        DATA,
        CSUM,
        RUN,
        ERR
    } ldr_state_t;

    // Width of the frame word-count field and of the word counter.
    localparam int LEN_W = 16;

endpackage : loader_pkg

// File: rtl/imem_loader_word_assembler.sv
// Packs accepted stream bytes into a little-endian 32-bit word.
// Latency: word_dat/word_done valid the cycle after the 4th byte is accepted.
// Backpressure: none; consumes a byte whenever accept is high.
//
// Ports: sysclk/reset (sync, active-low), byte_dat + accept (byte strobe),
// clear (drop any partial word), word_dat (shift register), byte_cnt
// (bytes held, mod 4), word_done (one-cycle pulse after the 4th byte).
module word_assembler (
    input  logic        sysclk,
    input  logic        reset,
    input  logic [7:0]  byte_dat,
    input  logic        accept,
    input  logic        clear,
    output logic [31:0] word_dat,
    output logic [1:0]  byte_cnt,
    output logic        word_done
);

    always_ff @(posedge sysclk) begin
        if (!reset || clear) begin
            word_dat  <= '0;
            byte_cnt  <= '0;
            word_done <= 1'b0;
        end else begin
            word_done <= accept && (byte_cnt == 2'd3);
            if (accept) begin
                // Shift right, new byte in at the top: after four bytes the
                // first one received sits in bits [7:0].
                word_dat <= {byte_dat, word_dat[31:8]};
                byte_cnt <= byte_cnt + 2'd1;
            end
        end
    end

endmodule : word_assembler

// File: rtl/imem_loader.sv
// Loads a framed byte stream into instruction memory, checks XOR, releases CPU.
// Latency: mem_we two edges after a word's 4th byte; cpu_run/err on the CSUM edge.
// Backpressure: in_ready depends on state only; low in RUN and ERR.
//
// Ports: sysclk, reset (sync, active-low); in_data/in_valid/in_ready byte
// stream; reload (restart, honoured only in RUN); mem_we/mem_addr/mem_wdata
// registered word write port; cpu_run (program verified); err (sticky).
module imem_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              sysclk,
    input  logic              reset,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              reload,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_run,
    output logic              err
);

    localparam int DEPTH = 2 ** ADDR_W;
    // One extra bit so DEPTH itself is representable when ADDR_W == LEN_W.
    localparam logic [LEN_W:0] DEPTH_X = (LEN_W + 1)'(DEPTH);

    ldr_state_t       state_q, state_d;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] word_cnt;
    logic [7:0]       xor_q;

    logic [31:0]      asm_word;
    logic [1:0]       asm_cnt;
    logic             asm_done;

    logic             accept;
    logic             pay_acc;
    logic             last_byte;
    logic             do_reload;
    logic [LEN_W-1:0] len_n;

    assign accept    = in_valid && in_ready;
    assign pay_acc   = accept && (state_q == DATA);
    assign do_reload = reload && (state_q == RUN);
    assign len_n     = {in_data, len_q[7:0]};
    // word_cnt only advances on the registered done pulse, so while the
    // 4th byte of word i is on the bus it still reads i.
    assign last_byte = pay_acc && (asm_cnt == 2'd3) &&
                       ((word_cnt + LEN_W'(1)) == len_q);

    word_assembler u_asm (
        .sysclk    (sysclk),
        .reset     (reset),
        .byte_dat  (in_data),
        .accept    (pay_acc),
        .clear     (do_reload),
        .word_dat  (asm_word),
        .byte_cnt  (asm_cnt),
        .word_done (asm_done)
    );

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        cpu_run  = 1'b0;
        err      = 1'b0;
        case (state_q)
            LEN0: begin
                in_ready = 1'b1;
                if (accept) state_d = LEN1;
            end
            LEN1: begin
                in_ready = 1'b1;
                if (accept) begin
                    if ({1'b0, len_n} > DEPTH_X) state_d = ERR;
                    else if (len_n == '0)        state_d = CSUM;
                    else                         state_d = DATA;
                end
            end
            DATA: begin
                in_ready = 1'b1;
                if (last_byte) state_d = CSUM;
            end
            CSUM: begin
                in_ready = 1'b1;
                if (accept) state_d = (in_data == xor_q) ? RUN : ERR;
            end
            RUN: begin
                cpu_run = 1'b1;
                if (reload) state_d = LEN0;
            end
            ERR: begin
                err = 1'b1;
            end
            default: state_d = ERR;
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (!reset) begin
            state_q   <= LEN0;
            len_q     <= '0;
            word_cnt  <= '0;
            xor_q     <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state_q <= state_d;
            mem_we  <= asm_done;

            if (accept && (state_q == LEN0)) len_q[7:0]  <= in_data;
            if (accept && (state_q == LEN1)) len_q[15:8] <= in_data;

            if (pay_acc) xor_q <= xor_q ^ in_data;

            if (asm_done) begin
                mem_addr  <= word_cnt[ADDR_W-1:0];
                mem_wdata <= asm_word;
                word_cnt  <= word_cnt + LEN_W'(1);
            end

            if (do_reload) begin
                len_q    <= '0;
                word_cnt <= '0;
                xor_q    <= '0;
            end
        end
    end

endmodule : imem_loader
